// File: rtl/inst_fetch_buffer_pkg.sv
// Shared defines and constants for the instruction fetch buffer.
// Defines are guarded so an existing project-wide header takes precedence.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD {`WORD_WIDTH{1'b0}}
`endif
`ifndef RESET_PC
`define RESET_PC 32'h0000_0000
`endif
`ifndef INST_ALIGN_W
`define INST_ALIGN_W 2
`endif

package inst_fetch_buffer_pkg;

    localparam int unsigned InstAlignW = `INST_ALIGN_W;
    localparam int unsigned PcStep     = 1 << InstAlignW;

endpackage

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs; clear empties it in one cycle.
// The head word is read straight from the storage registers.
module fetch_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_buffer.sv
// IF stage: sequential fetch over a single-outstanding req/ack port, buffered into fetch_fifo.
// Define IF_BYPASS_EN to forward an ack straight to the decoder when the FIFO is empty.
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int unsigned  W        = `WORD_WIDTH,
    parameter int unsigned  DEPTH    = 4,
    parameter logic [W-1:0] RESET_PC = `RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [W-1:0] redirect_pc,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         inst_valid,
    output logic         bubble
);

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [W-1:0] AlignMask = ~W'(PcStep - 1);

    logic [W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [W-1:0]   addr_q;
    logic           inflight_q, inflight_d;
    logic           drop_q, drop_d;
    logic           accepted;
    logic           take;
    logic           bypass;
    logic           head_valid;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [2*W-1:0] fifo_rdata;

    // A pending request keeps its original address even after a redirect moves fetch_pc.
    assign imem_req  = !rst && (inflight_q || (fifo_count < DepthC));
    assign imem_addr = inflight_q ? addr_q : fetch_pc_q;
    assign accepted  = imem_req && imem_ack;
    assign take      = accepted && !drop_q && !redirect;

`ifdef IF_BYPASS_EN
    assign bypass    = take && fifo_empty;
    assign fifo_push = take && (!bypass || stall);
`else
    assign bypass    = 1'b0;
    assign fifo_push = take;
`endif

    assign head_valid = !fifo_empty;
    assign fifo_pop   = head_valid && !stall && !redirect;

    fetch_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({imem_addr, imem_rdata}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        inst_valid = head_valid || bypass;
        bubble     = !inst_valid;
        inst       = `ZERO_WORD;
        inst_pc    = `ZERO_WORD;
        if (head_valid) begin
            inst    = fifo_rdata[W-1:0];
            inst_pc = fifo_rdata[2*W-1:W];
        end else if (bypass) begin
            inst    = imem_rdata;
            inst_pc = imem_addr;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = imem_req && !imem_ack;
        drop_d     = drop_q;
        if (accepted) begin
            drop_d = 1'b0;
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc & AlignMask;
            drop_d     = imem_req && !imem_ack;
        end else if (take) begin
            fetch_pc_d = fetch_pc_q + W'(PcStep);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= imem_addr;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // The issue rule never lets a push land on a full FIFO without a matching pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_overflow: assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer; memory returns addr + DataKey unless overridden.
module tb_inst_fetch_buffer;

    localparam logic [31:0] DataKey = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack, inst_valid, bubble;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
    logic        ack_en, ovr_en;
    logic [31:0] ovr_data;
    int          checks = 0;
    int          failures = 0;
    int          pushes;

    always #5 clk = ~clk;

    assign imem_ack   = ack_en;
    assign imem_rdata = ovr_en ? ovr_data : imem_addr + DataKey;

    inst_fetch_buffer u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .bubble      (bubble)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ack_en      = 1'b1;
        ovr_en      = 1'b0;
        ovr_data    = 32'h0;
        step();
        step();
        check_eq("rst_req", {31'b0, imem_req}, 32'h0);
        check_eq("rst_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("rst_bubble", {31'b0, bubble}, 32'h1);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef IF_BYPASS_EN
        do_reset();
        for (int i = 0; i < 40 && imem_addr != 32'h40; i++) step();
        check_eq("byp_reach_40", imem_addr, 32'h40);
        stall    = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'h2408_0005;
        #1;
        check_eq("byp_inst", inst, 32'h2408_0005);
        check_eq("byp_pc", inst_pc, 32'h40);
        check_eq("byp_valid", {31'b0, inst_valid}, 32'h1);
        check_eq("byp_bubble", {31'b0, bubble}, 32'h0);
        step();
        ack_en = 1'b0;
        ovr_en = 1'b0;
        #1;
        check_eq("byp_hold_inst", inst, 32'h2408_0005);
        check_eq("byp_hold_pc", inst_pc, 32'h40);
        check_eq("byp_hold_valid", {31'b0, inst_valid}, 32'h1);
`else
        // Streaming with ack every cycle.
        do_reset();
        check_eq("s_req0", {31'b0, imem_req}, 32'h1);
        check_eq("s_addr0", imem_addr, 32'h0);
        check_eq("s_valid0", {31'b0, inst_valid}, 32'h0);
        step();
        check_eq("s_valid1", {31'b0, inst_valid}, 32'h1);
        check_eq("s_pc1", inst_pc, 32'h0);
        check_eq("s_inst1", inst, DataKey);
        check_eq("s_addr1", imem_addr, 32'h4);
        step();
        check_eq("s_pc2", inst_pc, 32'h4);
        check_eq("s_inst2", inst, DataKey + 32'h4);
        check_eq("s_addr2", imem_addr, 32'h8);
        step();
        check_eq("s_pc3", inst_pc, 32'h8);

        // Stall fills the FIFO, then drains in order.
        do_reset();
        stall  = 1'b1;
        pushes = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_ack) pushes++;
            step();
        end
        check_eq("st_pushes", pushes, 32'd4);
        check_eq("st_req_off", {31'b0, imem_req}, 32'h0);
        check_eq("st_head_pc", inst_pc, 32'h0);
        check_eq("st_head_inst", inst, DataKey);
        stall = 1'b0;
        #1;
        check_eq("dr_pc0", inst_pc, 32'h0);
        step();
        check_eq("dr_pc1", inst_pc, 32'h4);
        check_eq("dr_req", {31'b0, imem_req}, 32'h1);
        check_eq("dr_addr", imem_addr, 32'h10);
        step();
        check_eq("dr_pc2", inst_pc, 32'h8);
        step();
        check_eq("dr_pc3", inst_pc, 32'hC);
        step();
        check_eq("dr_pc4", inst_pc, 32'h10);

        // Redirect while a request is held: old data dropped.
        do_reset();
        step();
        step();
        ack_en = 1'b0;
        #1;
        check_eq("rd_hold_addr", imem_addr, 32'h8);
        check_eq("rd_hold_req", {31'b0, imem_req}, 32'h1);
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        check_eq("rd_addr_c3", imem_addr, 32'h8);
        step();
        redirect = 1'b0;
        #1;
        check_eq("rd_addr_c4", imem_addr, 32'h8);
        check_eq("rd_valid_c4", {31'b0, inst_valid}, 32'h0);
        step();
        ack_en = 1'b1;
        #1;
        check_eq("rd_addr_c5", imem_addr, 32'h8);
        step();
        check_eq("rd_new_addr", imem_addr, 32'h100);
        check_eq("rd_valid_c6", {31'b0, inst_valid}, 32'h0);
        step();
        check_eq("rd_out_valid", {31'b0, inst_valid}, 32'h1);
        check_eq("rd_out_pc", inst_pc, 32'h100);
        check_eq("rd_out_inst", inst, DataKey + 32'h100);

        // Redirect coinciding with ack and pop.
        do_reset();
        step();
        step();
        check_eq("rc_pre_pc", inst_pc, 32'h4);
        check_eq("rc_pre_addr", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        step();
        redirect = 1'b0;
        #1;
        check_eq("rc_valid", {31'b0, inst_valid}, 32'h0);
        check_eq("rc_bubble", {31'b0, bubble}, 32'h1);
        check_eq("rc_inst", inst, 32'h0);
        check_eq("rc_inst_pc", inst_pc, 32'h0);
        check_eq("rc_addr", imem_addr, 32'h200);
        check_eq("rc_req", {31'b0, imem_req}, 32'h1);
        step();
        check_eq("rc_next_pc", inst_pc, 32'h200);

        // Fetch address wraps at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        step();
        redirect = 1'b0;
        #1;
        check_eq("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        check_eq("wr_addr_wrap", imem_addr, 32'h0);
        check_eq("wr_pc", inst_pc, 32'hFFFF_FFFC);
        check_eq("wr_inst", inst, 32'h0FFF_FFFC);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
